// File: rtl/pcie_tag_mode_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | pcie_tag_mode_tracker                                                      |
// | Per-PF/VF PCIe tag-mode tracker fed by the PCIe SS control-shadow stream;  |
// | VF table built only when PCIE_TAG_VF_TRACK_EN is defined.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pcie_tag_mode_tracker #(
    parameter int NUM_PF = 8,
    parameter int NUM_VF = 64,
    parameter int REG_IN = 1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrlshdw_tvalid,
    input  logic [39:0]           ctrlshdw_tdata,
    output logic [3*NUM_PF-1:0]   pf_tag_mode,
    output logic [2:0]            tag_mode_min,
    input  logic                  lkup_valid,
    input  logic [2:0]            lkup_pf,
    input  logic [10:0]           lkup_vf,
    input  logic                  lkup_vf_active,
    output logic                  lkup_rsp_valid,
    output logic [2:0]            lkup_rsp_mode,
    output logic                  chg_valid,
    output logic [2:0]            chg_pf,
    output logic [10:0]           chg_vf,
    output logic                  chg_vf_active,
    output logic [CNT_W-1:0]      chg_cnt,
    output logic                  err_range
);

    localparam logic [2:0] c_MODE_5B  = 3'b001;
    localparam logic [2:0] c_MODE_8B  = 3'b010;
    localparam logic [2:0] c_MODE_10B = 3'b100;

    logic        w_s1_valid;
    logic [39:0] w_s1_data;

    generate
        if (REG_IN != 0) begin : g_reg_in
            logic        r_valid;
            logic [39:0] r_data;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= ctrlshdw_tvalid;
                    r_data  <= ctrlshdw_tdata;
                end
            end
            assign w_s1_valid = r_valid;
            assign w_s1_data  = r_data;
        end else begin : g_no_reg_in
            assign w_s1_valid = ctrlshdw_tvalid;
            assign w_s1_data  = ctrlshdw_tdata;
        end
    endgenerate

    logic [2:0]  w_rec_pf;
    logic [10:0] w_rec_vf;
    logic        w_rec_vfa;
    logic        w_rec_ext;
    logic        w_rec_en10;
    logic [2:0]  w_rec_mode;
    logic        w_rec_pf_oor;

    assign w_rec_pf     = w_s1_data[2:0];
    assign w_rec_vf     = w_s1_data[13:3];
    assign w_rec_vfa    = w_s1_data[14];
    assign w_rec_ext    = w_s1_data[29];
    assign w_rec_en10   = w_s1_data[30];
    assign w_rec_mode   = !w_rec_ext ? c_MODE_5B : (w_rec_en10 ? c_MODE_10B : c_MODE_8B);
    assign w_rec_pf_oor = ({1'b0, w_rec_pf} >= 4'(NUM_PF));

    logic w_unused_data;
    assign w_unused_data = &{1'b0, w_s1_data[39:31], w_s1_data[28:15]};

    logic       w_wr_pf;
    logic       w_wr_any;
    logic       w_rng_err;
    logic [2:0] w_old;
    logic [2:0] w_lk_mode;
    logic [2:0] w_pf_tbl [NUM_PF];

    generate
        for (genvar gi = 0; gi < NUM_PF; gi++) begin : g_pf
            logic [2:0] r_mode;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_mode <= c_MODE_5B;
                else if (w_wr_pf && (w_rec_pf == 3'(gi)))
                    r_mode <= w_rec_mode;
            end
            assign w_pf_tbl[gi]              = r_mode;
            assign pf_tag_mode[3*gi +: 3]    = r_mode;
        end
    endgenerate

    // PF reads fall back to 5-bit when the index matches no tracked PF
    logic [2:0] w_pf_old;
    logic [2:0] w_lk_pf_mode;
    always_comb begin
        w_pf_old     = c_MODE_5B;
        w_lk_pf_mode = c_MODE_5B;
        for (int i = 0; i < NUM_PF; i++) begin
            if (w_rec_pf == 3'(i)) w_pf_old     = w_pf_tbl[i];
            if (lkup_pf  == 3'(i)) w_lk_pf_mode = w_pf_tbl[i];
        end
        if (w_wr_pf && (w_rec_pf == lkup_pf))
            w_lk_pf_mode = w_rec_mode;
    end

`ifdef PCIE_TAG_VF_TRACK_EN
    localparam int c_VF_IW = (NUM_VF > 1) ? $clog2(NUM_VF) : 1;

    logic       w_rec_vf_oor;
    logic       w_lk_pf_oor;
    logic       w_lk_vf_oor;
    logic       w_wr_vf;
    logic [2:0] w_vf_tbl [NUM_VF];
    logic [2:0] w_vf_old;
    logic [2:0] w_lk_vf_mode;

    assign w_rec_vf_oor = ({1'b0, w_rec_vf} >= 12'(NUM_VF));
    assign w_lk_pf_oor  = ({1'b0, lkup_pf}  >= 4'(NUM_PF));
    assign w_lk_vf_oor  = ({1'b0, lkup_vf}  >= 12'(NUM_VF));
    assign w_rng_err    = w_s1_valid && (w_rec_pf_oor || (w_rec_vfa && w_rec_vf_oor));
    assign w_wr_pf      = w_s1_valid && !w_rng_err && !w_rec_vfa;
    assign w_wr_vf      = w_s1_valid && !w_rng_err &&  w_rec_vfa;
    assign w_wr_any     = w_wr_pf || w_wr_vf;

    generate
        for (genvar gv = 0; gv < NUM_VF; gv++) begin : g_vf
            logic [2:0] r_mode;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_mode <= c_MODE_5B;
                else if (w_wr_vf && (w_rec_vf == 11'(gv)))
                    r_mode <= w_rec_mode;
            end
            assign w_vf_tbl[gv] = r_mode;
        end
    endgenerate

    assign w_vf_old = w_rec_vf_oor ? c_MODE_5B : w_vf_tbl[w_rec_vf[c_VF_IW-1:0]];
    assign w_old    = w_rec_vfa ? w_vf_old : w_pf_old;

    always_comb begin
        w_lk_vf_mode = w_lk_vf_oor ? c_MODE_5B : w_vf_tbl[lkup_vf[c_VF_IW-1:0]];
        if (w_wr_vf && (w_rec_vf == lkup_vf))
            w_lk_vf_mode = w_rec_mode;
        if (w_lk_pf_oor || w_lk_vf_oor)
            w_lk_vf_mode = c_MODE_5B;
    end

    assign w_lk_mode = lkup_vf_active ? w_lk_vf_mode : w_lk_pf_mode;
`else
    // Without VF storage, VF records are dropped silently and VF lookups alias to their PF
    assign w_rng_err = w_s1_valid && !w_rec_vfa && w_rec_pf_oor;
    assign w_wr_pf   = w_s1_valid && !w_rec_vfa && !w_rec_pf_oor;
    assign w_wr_any  = w_wr_pf;
    assign w_old     = w_pf_old;
    assign w_lk_mode = w_lk_pf_mode;

    logic w_unused_vf;
    assign w_unused_vf = &{1'b0, lkup_vf, lkup_vf_active, (NUM_VF > 0)};
`endif

    logic w_chg;
    assign w_chg = w_wr_any && (w_rec_mode != w_old);

    logic w_any_5b;
    logic w_any_8b;
    always_comb begin
        w_any_5b = 1'b0;
        w_any_8b = 1'b0;
        for (int i = 0; i < NUM_PF; i++) begin
            w_any_5b = w_any_5b | w_pf_tbl[i][0];
            w_any_8b = w_any_8b | w_pf_tbl[i][1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_mode_min   <= c_MODE_5B;
            chg_valid      <= 1'b0;
            chg_pf         <= '0;
            chg_vf         <= '0;
            chg_vf_active  <= 1'b0;
            chg_cnt        <= '0;
            err_range      <= 1'b0;
            lkup_rsp_valid <= 1'b0;
            lkup_rsp_mode  <= c_MODE_5B;
        end else begin
            tag_mode_min   <= w_any_5b ? c_MODE_5B : (w_any_8b ? c_MODE_8B : c_MODE_10B);
            chg_valid      <= w_chg;
            err_range      <= w_rng_err;
            lkup_rsp_valid <= lkup_valid;
            if (lkup_valid)
                lkup_rsp_mode <= w_lk_mode;
            if (w_chg) begin
                chg_pf        <= w_rec_pf;
                chg_vf        <= w_rec_vf;
                chg_vf_active <= w_rec_vfa;
                if (chg_cnt != {CNT_W{1'b1}})
                    chg_cnt <= chg_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcie_tag_mode_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_pcie_tag_mode_tracker                                                   |
// | Directed bench: unit A (8 PF, REG_IN=1, CNT_W=4), unit B (4 PF, REG_IN=0). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pcie_tag_mode_tracker;

`ifdef PCIE_TAG_VF_TRACK_EN
    localparam bit c_VF_EN = 1'b1;
`else
    localparam bit c_VF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_tvalid, b_tvalid;
    logic [39:0] a_tdata,  b_tdata;
    logic        lkup_valid;
    logic [2:0]  lkup_pf;
    logic [10:0] lkup_vf;
    logic        lkup_vf_active;

    logic [23:0] a_pf_mode;
    logic [2:0]  a_min, a_rsp_mode, a_chg_pf;
    logic        a_rsp_valid, a_chg_valid, a_chg_vfa, a_err;
    logic [10:0] a_chg_vf;
    logic [3:0]  a_chg_cnt;

    logic [11:0] b_pf_mode;
    logic [2:0]  b_min, b_rsp_mode, b_chg_pf;
    logic        b_rsp_valid, b_chg_valid, b_chg_vfa, b_err;
    logic [10:0] b_chg_vf;
    logic [15:0] b_chg_cnt;

    pcie_tag_mode_tracker #(.NUM_PF(8), .NUM_VF(64), .REG_IN(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .ctrlshdw_tvalid(a_tvalid), .ctrlshdw_tdata(a_tdata),
        .pf_tag_mode(a_pf_mode), .tag_mode_min(a_min),
        .lkup_valid(lkup_valid), .lkup_pf(lkup_pf), .lkup_vf(lkup_vf),
        .lkup_vf_active(lkup_vf_active),
        .lkup_rsp_valid(a_rsp_valid), .lkup_rsp_mode(a_rsp_mode),
        .chg_valid(a_chg_valid), .chg_pf(a_chg_pf), .chg_vf(a_chg_vf),
        .chg_vf_active(a_chg_vfa), .chg_cnt(a_chg_cnt), .err_range(a_err)
    );

    pcie_tag_mode_tracker #(.NUM_PF(4), .NUM_VF(64), .REG_IN(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .ctrlshdw_tvalid(b_tvalid), .ctrlshdw_tdata(b_tdata),
        .pf_tag_mode(b_pf_mode), .tag_mode_min(b_min),
        .lkup_valid(lkup_valid), .lkup_pf(lkup_pf), .lkup_vf(lkup_vf),
        .lkup_vf_active(lkup_vf_active),
        .lkup_rsp_valid(b_rsp_valid), .lkup_rsp_mode(b_rsp_mode),
        .chg_valid(b_chg_valid), .chg_pf(b_chg_pf), .chg_vf(b_chg_vf),
        .chg_vf_active(b_chg_vfa), .chg_cnt(b_chg_cnt), .err_range(b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] rec(input logic [2:0] pf, input logic [10:0] vf,
                                        input logic vfa, input logic ext, input logic en10);
        logic [39:0] d;
        d        = '0;
        d[2:0]   = pf;
        d[13:3]  = vf;
        d[14]    = vfa;
        d[29]    = ext;
        d[30]    = en10;
        return d;
    endfunction

    task automatic send_a(input logic [39:0] d);
        a_tvalid = 1'b1;
        a_tdata  = d;
        tick();
        a_tvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_tvalid = 1'b0; a_tdata = '0;
        b_tvalid = 1'b0; b_tdata = '0;
        lkup_valid = 1'b0; lkup_pf = '0; lkup_vf = '0; lkup_vf_active = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_pf_mode", 64'(a_pf_mode), 64'h249249);
        chk("rst_min",     64'(a_min),     64'h1);
        chk("rst_cnt",     64'(a_chg_cnt), 64'h0);
        chk("rst_chg",     64'(a_chg_valid), 64'h0);
        chk("rst_rsp",     64'(a_rsp_mode), 64'h1);
        chk("rst_b_pf",    64'(b_pf_mode), 64'h249);

        // PF2 -> 10-bit, visible two cycles after the record
        send_a(rec(3'd2, 11'd0, 1'b0, 1'b1, 1'b1));
        chk("pf2_early_chg",  64'(a_chg_valid), 64'h0);
        chk("pf2_early_mode", 64'(a_pf_mode),   64'h249249);
        tick();
        chk("pf2_mode",   64'(a_pf_mode),   64'h249309);
        chk("pf2_chg",    64'(a_chg_valid), 64'h1);
        chk("pf2_chg_pf", 64'(a_chg_pf),    64'h2);
        chk("pf2_cnt",    64'(a_chg_cnt),   64'h1);
        tick();
        chk("pf2_min",    64'(a_min),       64'h1);
        chk("pf2_pulse",  64'(a_chg_valid), 64'h0);
        send_a(rec(3'd2, 11'd0, 1'b0, 1'b1, 1'b1));
        tick();
        chk("dup_chg", 64'(a_chg_valid), 64'h0);
        chk("dup_cnt", 64'(a_chg_cnt),   64'h1);

        // All PFs 8-bit, back-to-back
        a_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_tdata = rec(3'(i), 11'd0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        a_tvalid = 1'b0;
        tick();
        chk("all8_mode",   64'(a_pf_mode),   64'h492492);
        chk("all8_min_lat", 64'(a_min),      64'h1);
        chk("all8_chg",    64'(a_chg_valid), 64'h1);
        chk("all8_chg_pf", 64'(a_chg_pf),    64'h7);
        chk("all8_cnt",    64'(a_chg_cnt),   64'h9);
        tick();
        chk("all8_min",    64'(a_min),       64'h2);
        send_a(rec(3'd0, 11'd0, 1'b0, 1'b0, 1'b1));
        tick();
        chk("pf0_5b_mode", 64'(a_pf_mode), 64'h492491);
        chk("pf0_5b_cnt",  64'(a_chg_cnt), 64'hA);
        tick();
        chk("pf0_5b_min",  64'(a_min),     64'h1);

        // VF write with same-cycle lookup (bypass)
        a_tvalid = 1'b1;
        a_tdata  = rec(3'd0, 11'd5, 1'b1, 1'b1, 1'b1);
        tick();
        a_tvalid = 1'b0;
        lkup_valid = 1'b1; lkup_pf = 3'd0; lkup_vf = 11'd5; lkup_vf_active = 1'b1;
        tick();
        lkup_valid = 1'b0;
        chk("vf_byp_valid", 64'(a_rsp_valid), 64'h1);
        chk("vf_byp_mode",  64'(a_rsp_mode),  c_VF_EN ? 64'h4 : 64'h1);
        chk("vf_chg",       64'(a_chg_valid), c_VF_EN ? 64'h1 : 64'h0);
        chk("vf_chg_vf",    64'(a_chg_vf),    c_VF_EN ? 64'h5 : 64'h0);
        chk("vf_chg_vfa",   64'(a_chg_vfa),   c_VF_EN ? 64'h1 : 64'h0);
        chk("vf_cnt",       64'(a_chg_cnt),   c_VF_EN ? 64'hB : 64'hA);
        chk("vf_err",       64'(a_err),       64'h0);
        tick();
        chk("rsp_valid_drop", 64'(a_rsp_valid), 64'h0);
        lkup_valid = 1'b1;
        tick();
        lkup_valid = 1'b0;
        chk("vf_stored", 64'(a_rsp_mode), c_VF_EN ? 64'h4 : 64'h1);
        lkup_valid = 1'b1; lkup_vf_active = 1'b0; lkup_pf = 3'd1;
        tick();
        lkup_valid = 1'b0;
        chk("pf1_lookup", 64'(a_rsp_mode), 64'h2);

        // VF out of range
        send_a(rec(3'd0, 11'd64, 1'b1, 1'b1, 1'b1));
        tick();
        chk("vf64_err", 64'(a_err),       c_VF_EN ? 64'h1 : 64'h0);
        chk("vf64_chg", 64'(a_chg_valid), 64'h0);
        chk("vf64_cnt", 64'(a_chg_cnt),   c_VF_EN ? 64'hB : 64'hA);
        tick();
        chk("vf64_err_pulse", 64'(a_err), 64'h0);
        lkup_valid = 1'b1; lkup_vf_active = 1'b1; lkup_vf = 11'd64; lkup_pf = 3'd1;
        tick();
        lkup_valid = 1'b0;
        chk("vf64_lookup", 64'(a_rsp_mode), c_VF_EN ? 64'h1 : 64'h2);

        // Counter saturation with CNT_W=4
        a_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_tdata = rec(3'd1, 11'd0, 1'b0, (i % 2) == 0, (i % 2) == 0);
            tick();
        end
        a_tvalid = 1'b0;
        tick();
        chk("sat_cnt",  64'(a_chg_cnt),   64'hF);
        chk("sat_chg",  64'(a_chg_valid), 64'h1);
        chk("sat_mode", 64'(a_pf_mode),   64'h492489);

        // Reset with a record in flight
        send_a(rec(3'd3, 11'd0, 1'b0, 1'b1, 1'b1));
        rst_n = 1'b0;
        #2;
        chk("arst_pf_mode", 64'(a_pf_mode),   64'h249249);
        chk("arst_min",     64'(a_min),       64'h1);
        chk("arst_cnt",     64'(a_chg_cnt),   64'h0);
        chk("arst_rsp",     64'(a_rsp_mode),  64'h1);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("lost_pf_mode", 64'(a_pf_mode),   64'h249249);
        chk("lost_chg",     64'(a_chg_valid), 64'h0);
        chk("lost_cnt",     64'(a_chg_cnt),   64'h0);

        // Unit B: NUM_PF=4, no input register
        b_tvalid = 1'b1;
        b_tdata  = rec(3'd7, 11'd0, 1'b0, 1'b1, 1'b1);
        tick();
        b_tvalid = 1'b0;
        chk("b_pf7_err",  64'(b_err),       64'h1);
        chk("b_pf7_mode", 64'(b_pf_mode),   64'h249);
        chk("b_pf7_chg",  64'(b_chg_valid), 64'h0);
        b_tvalid = 1'b1;
        b_tdata  = rec(3'd3, 11'd0, 1'b0, 1'b1, 1'b0);
        tick();
        b_tvalid = 1'b0;
        chk("b_pf3_mode",   64'(b_pf_mode),   64'h449);
        chk("b_pf3_chg",    64'(b_chg_valid), 64'h1);
        chk("b_pf3_chg_pf", 64'(b_chg_pf),    64'h3);
        chk("b_pf3_err",    64'(b_err),       64'h0);
        chk("b_pf3_cnt",    64'(b_chg_cnt),   64'h1);
        tick();
        chk("b_min", 64'(b_min), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
